// File: rtl/reset_seq_pkg.sv
// rtl/reset_seq_pkg.sv - shared state type, parameter defaults and helpers for the reset sequencer
package reset_seq_pkg;

    typedef enum logic [2:0] {
        HOLD     = 3'd0,
        COUNT    = 3'd1,
        RELEASE  = 3'd2,
        WAIT_ACK = 3'd3,
        DONE     = 3'd4
    } state_t;

    localparam int DEF_HOLD_CYCLES = 1000;
    localparam int DEF_GAP_CYCLES  = 16;
    localparam int DEF_ACK_TIMEOUT = 4096;

    // Largest of three cycle counts; sizes the shared timer.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// rtl/cycle_timer.sv - clearable incrementing counter with terminal-count compare
module cycle_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    input  logic [WIDTH-1:0] term,
    output logic             at_term
);

    logic [WIDTH-1:0] count;

    // Clear has priority over increment so every state/stage change restarts from zero.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + WIDTH'(1);
        end
    end

    assign at_term = (count == term);

endmodule

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - staged multi-domain reset release with init handshake and timeout
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_STAGES  = 4,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
    parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rst_req,
    input  logic                  init_done,
    output logic [NUM_STAGES-1:0] rst_out,
    output logic                  ready,
    output logic                  timeout_err
);

    localparam int CNT_W = $clog2(max3(HOLD_CYCLES, GAP_CYCLES, ACK_TIMEOUT)) + 1;
    localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    // Terminal counts are one less than the cycle counts since the timer starts at 0.
    localparam logic [CNT_W-1:0] HOLD_TERM = CNT_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] GAP_TERM  = CNT_W'((GAP_CYCLES  > 0) ? GAP_CYCLES  - 1 : 0);
    localparam logic [CNT_W-1:0] ACK_TERM  = CNT_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

    // Index of the stage whose gap expiry releases the final stage.
    localparam logic [IDX_W-1:0] LAST_GAP_IDX = IDX_W'((NUM_STAGES > 1) ? NUM_STAGES - 2 : 0);

    // With no gap (or a single domain) every stage releases on the hold expiry.
    localparam bit SKIP_RELEASE = (GAP_CYCLES == 0) || (NUM_STAGES == 1);

    localparam logic [NUM_STAGES-1:0] ALL_ONES = '1;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [NUM_STAGES-1:0]   rst_out_d;
    logic                    ready_d;
    logic                    timeout_err_d;
    logic                    tmr_clear, tmr_inc, tmr_at_term;
    logic [CNT_W-1:0]        tmr_term;

    cycle_timer #(.WIDTH(CNT_W)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (tmr_clear),
        .inc     (tmr_inc),
        .term    (tmr_term),
        .at_term (tmr_at_term)
    );

    // All outputs are flops so the domain resets never glitch.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= HOLD;
            idx_q       <= '0;
            rst_out     <= ALL_ONES;
            ready       <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            rst_out     <= rst_out_d;
            ready       <= ready_d;
            timeout_err <= timeout_err_d;
        end
    end

    // Next state, next registered outputs and timer control.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        rst_out_d     = rst_out;
        timeout_err_d = timeout_err;
        tmr_clear     = 1'b1;
        tmr_inc       = 1'b0;
        tmr_term      = HOLD_TERM;

        if (rst_req) begin
            state_d   = HOLD;
            idx_d     = '0;
            rst_out_d = ALL_ONES;
        end else begin
            case (state_q)
                HOLD: begin
                    state_d   = COUNT;
                    rst_out_d = ALL_ONES;
                end
                COUNT: begin
                    tmr_term = HOLD_TERM;
                    if (tmr_at_term) begin
                        idx_d = '0;
                        if (SKIP_RELEASE) begin
                            state_d   = WAIT_ACK;
                            rst_out_d = '0;
                        end else begin
                            state_d   = RELEASE;
                            rst_out_d = ALL_ONES << 1;
                        end
                    end else begin
                        tmr_clear = 1'b0;
                        tmr_inc   = 1'b1;
                    end
                end
                RELEASE: begin
                    tmr_term = GAP_TERM;
                    if (tmr_at_term) begin
                        if (idx_q == LAST_GAP_IDX) begin
                            state_d   = WAIT_ACK;
                            rst_out_d = '0;
                        end else begin
                            idx_d     = idx_q + IDX_W'(1);
                            rst_out_d = rst_out << 1;
                        end
                    end else begin
                        tmr_clear = 1'b0;
                        tmr_inc   = 1'b1;
                    end
                end
                WAIT_ACK: begin
                    tmr_term  = ACK_TERM;
                    rst_out_d = '0;
                    if (init_done) begin
                        state_d = DONE;
                    end else if (tmr_at_term) begin
                        state_d       = DONE;
                        timeout_err_d = 1'b1;
                    end else begin
                        tmr_clear = 1'b0;
                        tmr_inc   = 1'b1;
                    end
                end
                DONE: begin
                    rst_out_d = '0;
                end
                default: begin
                    state_d   = HOLD;
                    idx_d     = '0;
                    rst_out_d = ALL_ONES;
                end
            endcase
        end

        ready_d = (state_d == DONE);
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - scoreboard bench for reset_sequencer
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       rst_req;
    logic       init_done;
    logic [3:0] rst_out;
    logic       ready;
    logic       timeout_err;

    int cyc      = 0;
    int checks   = 0;
    int failures = 0;

    typedef struct {
        int         at;
        logic [3:0] ro;
        logic       rdy;
        logic       te;
        string      tag;
    } exp_t;

    exp_t sbq[$];

    reset_sequencer #(
        .NUM_STAGES  (4),
        .HOLD_CYCLES (4),
        .GAP_CYCLES  (2),
        .ACK_TIMEOUT (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rst_req     (rst_req),
        .init_done   (init_done),
        .rst_out     (rst_out),
        .ready       (ready),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog cycle=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic push(input int dly, input logic [3:0] ro, input logic rdy,
                        input logic te, input string tag);
        exp_t e;
        e.at  = cyc + dly;
        e.ro  = ro;
        e.rdy = rdy;
        e.te  = te;
        e.tag = tag;
        sbq.push_back(e);
    endtask

    task automatic sample();
        exp_t       e;
        logic [5:0] obs;
        logic [5:0] exp;
        while (sbq.size() > 0 && sbq[0].at <= cyc) begin
            e   = sbq.pop_front();
            obs = {rst_out, ready, timeout_err};
            exp = {e.ro, e.rdy, e.te};
            checks++;
            assert (obs === exp) else begin
                failures++;
                $error("FAIL %s cycle=%0d observed rst_out/ready/terr=%b expected=%b",
                       e.tag, cyc, obs, exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        sample();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Expected release staircase counted from the cycle rst_req/reset drops.
    task automatic release_seq(input logic te);
        push(1,  4'b1111, 1'b0, te, "hold_entry");
        push(4,  4'b1111, 1'b0, te, "count_end");
        push(5,  4'b1110, 1'b0, te, "stage0");
        push(6,  4'b1110, 1'b0, te, "stage0_gap");
        push(7,  4'b1100, 1'b0, te, "stage1");
        push(9,  4'b1000, 1'b0, te, "stage2");
        push(10, 4'b1000, 1'b0, te, "stage2_gap");
        push(11, 4'b0000, 1'b0, te, "stage3");
        run(11);
    endtask

    // Acknowledge two cycles after the last release; ready follows one cycle later.
    task automatic ack_end(input logic te);
        push(1, 4'b0000, 1'b0, te, "wait_ack");
        run(1);
        init_done = 1'b1;
        push(1, 4'b0000, 1'b1, te, "ready");
        run(1);
        init_done = 1'b0;
        push(2, 4'b0000, 1'b1, te, "done_hold");
        run(2);
    endtask

    initial begin
        reset     = 1'b1;
        rst_req   = 1'b0;
        init_done = 1'b0;
        run(2);
        push(0, 4'b1111, 1'b0, 1'b0, "reset_state");
        sample();

        // Nominal sequence out of reset
        reset = 1'b0;
        release_seq(1'b0);
        ack_end(1'b0);

        // Held request from DONE keeps every domain in reset
        rst_req = 1'b1;
        for (int i = 1; i <= 20; i++) push(i, 4'b1111, 1'b0, 1'b0, "held_req");
        run(20);
        rst_req = 1'b0;
        release_seq(1'b0);
        ack_end(1'b0);

        // Single-cycle request while rst_out=1100 aborts and restarts
        rst_req = 1'b1;
        run(1);
        rst_req = 1'b0;
        push(5, 4'b1110, 1'b0, 1'b0, "pre_abort_s0");
        push(7, 4'b1100, 1'b0, 1'b0, "pre_abort_s1");
        run(7);
        rst_req = 1'b1;
        push(1, 4'b1111, 1'b0, 1'b0, "abort");
        run(1);
        rst_req = 1'b0;
        release_seq(1'b0);
        ack_end(1'b0);

        // Timeout: no init_done
        rst_req = 1'b1;
        run(1);
        rst_req = 1'b0;
        release_seq(1'b0);
        push(7, 4'b0000, 1'b0, 1'b0, "pre_timeout");
        push(8, 4'b0000, 1'b1, 1'b1, "timeout");
        run(8);

        // A later request keeps the sticky error
        rst_req = 1'b1;
        push(1, 4'b1111, 1'b0, 1'b1, "req_keeps_terr");
        run(1);
        rst_req = 1'b0;
        release_seq(1'b1);
        ack_end(1'b1);

        // Reset and request together: reset values, error cleared
        reset   = 1'b1;
        rst_req = 1'b1;
        push(1, 4'b1111, 1'b0, 1'b0, "reset_and_req");
        run(1);
        reset   = 1'b0;
        rst_req = 1'b0;

        // init_done on the timeout cycle wins
        release_seq(1'b0);
        push(7, 4'b0000, 1'b0, 1'b0, "pre_tie");
        run(7);
        init_done = 1'b1;
        push(1, 4'b0000, 1'b1, 1'b0, "tie_ack_wins");
        run(1);
        init_done = 1'b0;

        // Reset mid-release drops the partial release immediately
        rst_req = 1'b1;
        run(1);
        rst_req = 1'b0;
        push(7, 4'b1100, 1'b0, 1'b0, "pre_reset_s1");
        run(7);
        reset = 1'b1;
        push(1, 4'b1111, 1'b0, 1'b0, "reset_abort");
        run(1);
        reset = 1'b0;
        release_seq(1'b0);
        ack_end(1'b0);

        checks++;
        assert (sbq.size() == 0) else begin
            failures++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", sbq.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
